// File: rtl/pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg
//
// Pipeline stage register with a valid/ready handshake, a synchronous flush and
// an optional two-entry skid buffer. Replaces the fixed instruction+PC stage
// registers between the core's pipeline stages. Back-pressure stalls the stage
// and `flush` kills its contents. Two saturating counters (stall cycles and
// killed entries) feed the performance-monitor CSRs.
//
// Parameters
//   DATA_W    payload width (default instr 32 + PC 64)
//   RESET_VAL value on out_data after reset and after flush
//   SKID      0: single register, combinational in_ready
//             1: two-entry skid buffer, registered in_ready
//   CNT_W     width of the performance counters
//
// Ports
//   clk        in   clock, all state changes on the rising edge
//   reset      in   synchronous active-high reset
//   in_valid   in   upstream offers in_data
//   in_ready   out  stage accepts data this cycle
//   in_data    in   upstream payload
//   out_valid  out  out_data holds a live entry
//   out_ready  in   downstream consumes this cycle
//   out_data   out  oldest held payload
//   flush      in   kill held entries and any entry accepted this cycle
//   cnt_clr    in   synchronous clear of both counters
//   stall_cnt  out  cycles with out_valid & !out_ready (saturating)
//   kill_cnt   out  live entries discarded by flush (saturating)
// -----------------------------------------------------------------------------
module pipe_stage_reg #(
    parameter int                 DATA_W    = 96,
    parameter logic [DATA_W-1:0]  RESET_VAL = '0,
    parameter int                 SKID      = 1,
    parameter int                 CNT_W     = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    input  logic              flush,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  kill_cnt
);

    logic       in_fire;
    logic       out_fire;
    logic [1:0] held;          // number of live entries currently stored

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    generate
        if (SKID != 0) begin : g_skid
            typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

            state_t             state_reg;
            logic [DATA_W-1:0]  main_reg;
            logic [DATA_W-1:0]  skid_reg;
            logic               in_ready_reg;

            assign in_ready  = in_ready_reg;
            assign out_valid = (state_reg != EMPTY);
            assign out_data  = main_reg;
            assign held      = (state_reg == FULL) ? 2'd2 :
                               (state_reg == ONE)  ? 2'd1 : 2'd0;

            // in_ready_reg is loaded with (next state != FULL) in every branch,
            // so in_ready never depends combinationally on out_ready.
            always_ff @(posedge clk) begin
                if (reset) begin
                    state_reg    <= EMPTY;
                    main_reg     <= RESET_VAL;
                    skid_reg     <= RESET_VAL;
                    in_ready_reg <= 1'b1;
                end else if (flush) begin
                    // Anything accepted this cycle is dropped with the rest.
                    state_reg    <= EMPTY;
                    main_reg     <= RESET_VAL;
                    in_ready_reg <= 1'b1;
                end else begin
                    in_ready_reg <= 1'b1;
                    case (state_reg)
                        EMPTY: begin
                            if (in_fire) begin
                                state_reg <= ONE;
                                main_reg  <= in_data;
                            end
                        end
                        ONE: begin
                            case ({in_fire, out_fire})
                                2'b11: main_reg <= in_data;
                                2'b10: begin
                                    // Downstream stalled: park the new item.
                                    state_reg    <= FULL;
                                    skid_reg     <= in_data;
                                    in_ready_reg <= 1'b0;
                                end
                                2'b01: state_reg <= EMPTY;
                                default: ;
                            endcase
                        end
                        FULL: begin
                            if (out_fire) begin
                                state_reg <= ONE;
                                main_reg  <= skid_reg;
                            end else begin
                                in_ready_reg <= 1'b0;
                            end
                        end
                        default: begin
                            state_reg <= EMPTY;
                        end
                    endcase
                end
            end
        end else begin : g_reg
            logic               valid_reg;
            logic [DATA_W-1:0]  data_reg;

            assign in_ready  = out_ready | ~valid_reg;
            assign out_valid = valid_reg;
            assign out_data  = data_reg;
            assign held      = {1'b0, valid_reg};

            always_ff @(posedge clk) begin
                if (reset || flush) begin
                    valid_reg <= 1'b0;
                    data_reg  <= RESET_VAL;
                end else if (in_fire) begin
                    valid_reg <= 1'b1;
                    data_reg  <= in_data;
                end else if (out_fire) begin
                    valid_reg <= 1'b0;
                end
            end
        end
    endgenerate

    // Counter increments: index 0 = stall, index 1 = kill.
    // The kill amount is held entries not delivered this cycle plus a newly
    // accepted one; it never exceeds 2, so 2-bit wraparound in the
    // intermediate subtraction is harmless.
    logic [1:0] cnt_inc [2];

    assign cnt_inc[0] = {1'b0, out_valid & ~out_ready};
    assign cnt_inc[1] = flush ? (held - {1'b0, out_fire} + {1'b0, in_fire}) : 2'd0;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_cnt
            logic [CNT_W-1:0] cnt_reg;
            logic [CNT_W:0]   sum_next;

            // One extra bit catches overflow; any carry means saturate.
            assign sum_next = {1'b0, cnt_reg} + (CNT_W+1)'(cnt_inc[gi]);

            always_ff @(posedge clk) begin
                if (reset || cnt_clr) begin
                    cnt_reg <= '0;
                end else if (sum_next[CNT_W]) begin
                    cnt_reg <= '1;
                end else begin
                    cnt_reg <= sum_next[CNT_W-1:0];
                end
            end
        end
    endgenerate

    assign stall_cnt = g_cnt[0].cnt_reg;
    assign kill_cnt  = g_cnt[1].cnt_reg;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// tb_pipe_stage_reg
//
// Drives one SKID=1 instance (CNT_W=4) and one SKID=0 instance (CNT_W=8) from
// the same input stimulus and checks both against a FIFO-occupancy reference
// model: directed scenarios first, then randomized traffic with flush,
// counter clear and reset sprinkled in.
// -----------------------------------------------------------------------------
module tb_pipe_stage_reg;

    localparam int             DW = 16;
    localparam logic [DW-1:0]  RV = 16'hA5C3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset, in_valid, out_ready, flush, cnt_clr;
    logic [DW-1:0] in_data;

    logic          s_in_ready, s_out_valid;
    logic [DW-1:0] s_out_data;
    logic [3:0]    s_stall, s_kill;

    logic          r_in_ready, r_out_valid;
    logic [DW-1:0] r_out_data;
    logic [7:0]    r_stall, r_kill;

    pipe_stage_reg #(.DATA_W(DW), .RESET_VAL(RV), .SKID(1), .CNT_W(4)) u_skid (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(s_in_ready),
        .in_data(in_data), .out_valid(s_out_valid), .out_ready(out_ready),
        .out_data(s_out_data), .flush(flush), .cnt_clr(cnt_clr),
        .stall_cnt(s_stall), .kill_cnt(s_kill)
    );

    pipe_stage_reg #(.DATA_W(DW), .RESET_VAL(RV), .SKID(0), .CNT_W(8)) u_reg (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(r_in_ready),
        .in_data(in_data), .out_valid(r_out_valid), .out_ready(out_ready),
        .out_data(r_out_data), .flush(flush), .cnt_clr(cnt_clr),
        .stall_cnt(r_stall), .kill_cnt(r_kill)
    );

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;
    int cyc = 0;

    // Reference model: per instance a FIFO of up to two items plus counters.
    int            mcnt   [2];
    logic [DW-1:0] mmem   [2][2];
    int            mstall [2];
    int            mkill  [2];
    bit            mknown [2];   // out_data known to be RESET_VAL while empty
    int            mmax   [2];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // SKID=1 accepts whenever there is room; SKID=0 only when empty or draining.
    function automatic bit m_ready(input int i);
        if (i == 0) return (mcnt[i] < 2);
        return (out_ready == 1'b1) || (mcnt[i] == 0);
    endfunction

    function automatic int sat(input int v, input int i);
        return (v > mmax[i]) ? mmax[i] : v;
    endfunction

    task automatic check_inst(input int i, input logic rdy, input logic vld,
                              input logic [DW-1:0] d, input logic [31:0] st,
                              input logic [31:0] kl);
        check_eq($sformatf("u%0d.in_ready", i), 32'(rdy), 32'(m_ready(i)));
        check_eq($sformatf("u%0d.out_valid", i), 32'(vld), 32'(mcnt[i] > 0));
        if (mcnt[i] > 0)
            check_eq($sformatf("u%0d.out_data", i), 32'(d), 32'(mmem[i][0]));
        else if (mknown[i])
            check_eq($sformatf("u%0d.out_data_rst", i), 32'(d), 32'(RV));
        check_eq($sformatf("u%0d.stall_cnt", i), st, 32'(mstall[i]));
        check_eq($sformatf("u%0d.kill_cnt", i), kl, 32'(mkill[i]));
    endtask

    task automatic model_step(input int i);
        bit rdy, of, inf;
        rdy = m_ready(i);
        of  = (mcnt[i] > 0) && (out_ready == 1'b1);
        inf = (in_valid == 1'b1) && rdy;
        if (reset) begin
            mcnt[i] = 0; mstall[i] = 0; mkill[i] = 0; mknown[i] = 1'b1;
        end else begin
            if (cnt_clr) begin
                mstall[i] = 0; mkill[i] = 0;
            end else begin
                if (mcnt[i] > 0 && !out_ready) mstall[i] = sat(mstall[i] + 1, i);
                if (flush) mkill[i] = sat(mkill[i] + mcnt[i] - int'(of) + int'(inf), i);
            end
            if (flush) begin
                mcnt[i] = 0; mknown[i] = 1'b1;
            end else begin
                if (of) begin
                    mmem[i][0] = mmem[i][1];
                    mcnt[i]--;
                end
                if (inf) begin
                    mmem[i][mcnt[i]] = in_data;
                    mcnt[i]++;
                    mknown[i] = 1'b0;
                end
            end
        end
    endtask

    // One clock cycle: apply inputs mid-cycle, check outputs, advance the model.
    task automatic cycle(input logic iv, input logic [DW-1:0] d, input logic ordy,
                         input logic fl, input logic clr, input logic rst);
        @(negedge clk);
        in_valid = iv; in_data = d; out_ready = ordy;
        flush = fl; cnt_clr = clr; reset = rst;
        #1;
        if (chk_en) begin
            check_inst(0, s_in_ready, s_out_valid, s_out_data, 32'(s_stall), 32'(s_kill));
            check_inst(1, r_in_ready, r_out_valid, r_out_data, 32'(r_stall), 32'(r_kill));
            $display("cyc %0d: in_v=%0d in_d=%h out_r=%0d fl=%0d clr=%0d rst=%0d skid_out=%h/%0d reg_out=%h/%0d",
                     cyc, iv, d, ordy, fl, clr, rst, s_out_data, s_out_valid, r_out_data, r_out_valid);
        end
        model_step(0);
        model_step(1);
        cyc++;
    endtask

    task automatic after_edge();
        @(posedge clk);
        #1;
    endtask

    initial begin
        mmax[0] = 15;
        mmax[1] = 255;
        reset = 1'b1; in_valid = 1'b0; in_data = '0;
        out_ready = 1'b0; flush = 1'b0; cnt_clr = 1'b0;

        // Reset; checks start once the first reset edge has been applied.
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk_en = 1'b1;
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);

        // Streaming 1..8 with out_ready=1: each item visible one cycle later.
        for (int k = 1; k <= 8; k++) begin
            cycle(1'b1, DW'(k), 1'b1, 1'b0, 1'b0, 1'b0);
            after_edge();
            check_eq("stream.skid_data", 32'(s_out_data), 32'(k));
            check_eq("stream.reg_data", 32'(r_out_data), 32'(k));
        end
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
        after_edge();
        check_eq("stream.stall", 32'(s_stall), 32'd0);

        // Back-pressure: A and B absorbed, C refused, then drained in order.
        cycle(1'b1, 16'h00A0, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 16'h00B0, 1'b0, 1'b0, 1'b0, 1'b0);
        after_edge();
        check_eq("bp.in_ready", 32'(s_in_ready), 32'd0);
        check_eq("bp.held_A", 32'(s_out_data), 32'h00A0);
        cycle(1'b1, 16'h00C0, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 16'h00C0, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 16'h00C0, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
        after_edge();
        check_eq("bp.stall", 32'(s_stall), 32'd2);

        // Flush while FULL with a refused offer.
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 16'h0011, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 16'h0022, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 16'h0033, 1'b0, 1'b1, 1'b0, 1'b0);
        after_edge();
        check_eq("flfull.out_valid", 32'(s_out_valid), 32'd0);
        check_eq("flfull.out_data", 32'(s_out_data), 32'(RV));
        check_eq("flfull.kill", 32'(s_kill), 32'd2);
        check_eq("flfull.in_ready", 32'(s_in_ready), 32'd1);

        // Flush from ONE with simultaneous input and output fire.
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 16'h0044, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 16'h0055, 1'b1, 1'b1, 1'b0, 1'b0);
        after_edge();
        check_eq("flone.kill", 32'(s_kill), 32'd1);
        check_eq("flone.out_valid", 32'(s_out_valid), 32'd0);

        // Stall counter saturation (CNT_W=4) and clear-wins-over-increment.
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 16'h0066, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 20; k++) cycle(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        after_edge();
        check_eq("sat.stall", 32'(s_stall), 32'd15);
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
        after_edge();
        check_eq("clr.stall", 32'(s_stall), 32'd0);

        // Reset in the middle of a stream.
        cycle(1'b1, 16'h0077, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 16'h0088, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 16'h0099, 1'b1, 1'b0, 1'b0, 1'b1);
        after_edge();
        check_eq("rst.skid_valid", 32'(s_out_valid), 32'd0);
        check_eq("rst.reg_valid", 32'(r_out_valid), 32'd0);

        // Randomized traffic.
        for (int n = 0; n < 500; n++) begin
            cycle(1'($urandom_range(0, 1)), DW'($urandom), ($urandom_range(0, 9) < 7),
                  ($urandom_range(0, 29) == 0), ($urandom_range(0, 49) == 0),
                  ($urandom_range(0, 99) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised pipeline stage register with a valid/ready handshake, a synchronous flush and an optional two-entry skid buffer. It replaces the fixed instruction+PC stage registers between fetch/decode/execute/memory/writeback. Stalling uses back-pressure (`out_ready`), not a global flush vector, and killing uses `flush`. Saturating stall and flush counters feed the performance-monitor CSRs.

## Interface
- `DATA_W`, 96: payload width; default is instr (32) + PC (64).
- `RESET_VAL`, 0: value driven on `out_data` after reset and after flush.
- `SKID`, 1: 0 = single register with combinational `in_ready`; 1 = two-entry skid buffer with registered `in_ready`.
- `CNT_W`, 32: width of the performance counters.
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  upstream offers `in_data`.
- `in_ready`  out  1  stage accepts data this cycle.
- `in_data`  in  DATA_W  upstream payload.
- `out_valid`  out  1  `out_data` holds a live entry.
- `out_ready`  in  1  downstream consumes this cycle.
- `out_data`  out  DATA_W  oldest held payload.
- `flush`  in  1  kill all held entries and any entry accepted this cycle.
- `cnt_clr`  in  1  synchronous clear of both counters.
- `stall_cnt`  out  CNT_W  cycles with `out_valid & !out_ready`, saturating.
- `kill_cnt`  out  CNT_W  live entries discarded by flush, saturating.

## Operation
- Handshakes:
  - Input fire = `in_valid & in_ready`.
  - Output fire = `out_valid & out_ready`.
  - `in_valid` does not depend on `in_ready`.
- SKID=0 (one data register, one valid bit):
  - `in_ready = out_ready | !out_valid`.
  - On input fire, the register loads `in_data` and `out_valid` is set.
  - On output fire without input fire, `out_valid` clears.
- SKID=1 uses a main register (drives `out_data`), a skid register, and states EMPTY, ONE, FULL:
  - EMPTY: input fire → ONE; main loads `in_data`.
  - ONE, input and output fire → ONE; main loads `in_data`.
  - ONE, input fire only → FULL; skid loads `in_data`.
  - ONE, output fire only → EMPTY.
  - FULL: output fire → ONE; main loads skid. No input fire is possible (`in_ready`=0).
  - `out_valid` = (state != EMPTY).
  - `in_ready` is a flop equal to (next state != FULL).
- Flush (priority: reset > flush > handshake):
  - Next state is EMPTY and `out_valid`=0 next cycle.
  - `out_data` is set to RESET_VAL.
  - Any input fire in the same cycle is discarded.
  - An output fire in the same cycle still counts as delivered; downstream already took it.
- `kill_cnt` += number of entries held at the flush edge that are not output-fired that cycle (0–2), plus 1 if an input fired that cycle.
- Counters:
  - Both saturate at 2^CNT_W−1 and never wrap.
  - `cnt_clr` zeroes both; if clear and increment coincide, clear wins.
  - `reset` also zeroes both.
- Payload is opaque; no field is interpreted.

## Timing
- Reset values: `out_valid`=0, `out_data`=RESET_VAL, `stall_cnt`=`kill_cnt`=0, state EMPTY.
- `in_ready`=1 from the first cycle after reset: a flop for SKID=1, combinational for SKID=0.
- Latency: an input fire in cycle N gives `out_valid`=1 with that data in cycle N+1.
- Throughput is one item per cycle in both modes while `out_ready`=1.
- SKID=1 absorbs exactly one extra item after `out_ready` drops. `in_ready` falls the cycle after the skid fills.
- No combinational path from `out_ready` to `in_ready` when SKID=1.
- Ordering is strictly FIFO; no item is duplicated or dropped except by flush.
- Reset mid-transfer discards all entries; counters are not incremented on that edge.

## Test plan
- SKID=1 streaming:
  - Stimulus: `in_valid`=1 with data 1..8 on consecutive cycles, `out_ready`=1.
  - Required: outputs 1..8 on cycles 2..9; `in_ready` constantly 1; `stall_cnt`=0.
- SKID=1 back-pressure:
  - Stimulus: hold `out_ready`=0 while offering A, B, C.
  - Required: A and B accepted; `in_ready`=0 before C; `out_data`=A held.
  - On release: A, B, C emerge in order; `stall_cnt` equals the number of held cycles.
- Flush while FULL with a new offer:
  - Stimulus: stage holds two entries, `out_ready`=0; assert `flush`.
  - Required: next cycle `out_valid`=0, `out_data`=RESET_VAL, `kill_cnt`=2, `in_ready`=1.
- Flush coinciding with an input fire from ONE, `out_ready`=1:
  - Required: `kill_cnt` +1 (the accepted item only); the delivered entry is not counted; next cycle EMPTY.
- Counter saturation and clear:
  - Stimulus: CNT_W=4, stall 20 cycles.
  - Required: `stall_cnt`=15.
  - Then `cnt_clr` together with a stall cycle: required 0.
- SKID=0 mode:
  - Required: same stream passes with 1-cycle latency.
  - `in_ready` follows `out_ready` in the same cycle when `out_valid`=1.
  - Reset asserted mid-stream gives `out_valid`=0 on the next edge.
